// File: rtl/tow_pkg.sv
// Shared definitions for the countdown bar controller: FSM states, result codes
// and the LED pattern helpers (thermometer bar and winner pattern).
package tow_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_SETTLE = 3'd2,
    S_SHOW   = 3'd3,
    S_DARK   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LEFT  = 2'b01;
  localparam logic [1:0] RES_RIGHT = 2'b10;
  localparam logic [1:0] RES_TIE   = 2'b11;

  localparam int MAX_W = 16;

  // n ones in the LSBs, clipped to a w-bit field
  function automatic logic [MAX_W-1:0] therm(input logic [4:0] n, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < w) && (i < int'(n));
    end
    return r;
  endfunction

  // right lights the low half, left the high half; the middle LED stays dark
  function automatic logic [MAX_W-1:0] win_pattern(input logic [1:0] res, input int w);
    logic [MAX_W-1:0] r;
    int half;
    half = (w - 1) / 2;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (res[1] && (i < half)) || (res[0] && (i >= w - half) && (i < w));
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_bar_ctrl.sv
// Thermometer countdown bar, one-cycle result strobe, then FLASHES winner flashes.
// Each state advances only on its own tick enable; abort returns to IDLE from anywhere.
module countdown_bar_ctrl
  import tow_pkg::*;
#(
  parameter int LED_W   = 7,
  parameter int FLASHES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             tick_step,
  input  logic             tick_flash,
  input  logic             tick_settle,
  input  logic [1:0]       result,
  output logic [LED_W-1:0] led,
  output logic             win_pulse,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(LED_W + 1);
  localparam int FW = (FLASHES > 1) ? $clog2(FLASHES) : 1;

  state_t        state, state_nxt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [FW-1:0] flash_cnt, flash_nxt;
  logic [1:0]    res_q, res_nxt;
  logic          settle_first, first_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      step_cnt     <= '0;
      flash_cnt    <= '0;
      res_q        <= RES_NONE;
      settle_first <= 1'b0;
    end else begin
      state        <= state_nxt;
      step_cnt     <= step_nxt;
      flash_cnt    <= flash_nxt;
      res_q        <= res_nxt;
      settle_first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    flash_nxt = flash_cnt;
    res_nxt   = res_q;
    first_nxt = 1'b0;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state_nxt = S_COUNT;
            step_nxt  = SW'(LED_W);
          end
        end
        S_COUNT: begin
          if (tick_step) begin
            step_nxt = step_cnt - SW'(1);
            if (step_cnt == SW'(1)) begin
              state_nxt = S_SETTLE;
              first_nxt = 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (tick_settle) begin
            res_nxt   = result;
            flash_nxt = '0;
            state_nxt = S_SHOW;
          end
        end
        S_SHOW: begin
          if (tick_flash) state_nxt = S_DARK;
        end
        S_DARK: begin
          if (tick_flash) begin
            if (flash_cnt == FW'(FLASHES - 1)) begin
              state_nxt = S_FINISH;
            end else begin
              flash_nxt = flash_cnt + FW'(1);
              state_nxt = S_SHOW;
            end
          end
        end
        S_FINISH: begin
          if (tick_step) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from registered state and counters only
  always_comb begin
    led = '0;
    case (state)
      S_COUNT: led = LED_W'(therm(5'(step_cnt), LED_W));
      S_SHOW:  led = LED_W'(win_pattern(res_q, LED_W));
      default: led = '0;
    endcase
  end

  assign win_pulse = (state == S_SETTLE) && settle_first;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);

endmodule

// File: tb/tb_countdown_bar_ctrl.sv
// Directed bench for countdown_bar_ctrl with LED_W=7, FLASHES=2.
module tb_countdown_bar_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tick_step = 1'b0;
  logic       tick_flash = 1'b0;
  logic       tick_settle = 1'b0;
  logic [1:0] result = 2'b00;
  logic [6:0] led;
  logic       win_pulse;
  logic       busy;
  logic       done;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  countdown_bar_ctrl #(.LED_W(7), .FLASHES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tick_step(tick_step), .tick_flash(tick_flash), .tick_settle(tick_settle),
    .result(result), .led(led), .win_pulse(win_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ts, input logic tf, input logic tse);
    tick_step = ts; tick_flash = tf; tick_settle = tse;
    step();
    tick_step = 1'b0; tick_flash = 1'b0; tick_settle = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [6:0] e_led, input logic e_win,
                      input logic e_busy, input logic e_done);
    chk({tag, "_led"},  32'(led),       32'(e_led));
    chk({tag, "_win"},  32'(win_pulse), 32'(e_win));
    chk({tag, "_busy"}, 32'(busy),      32'(e_busy));
    chk({tag, "_done"}, 32'(done),      32'(e_done));
  endtask

  logic [6:0] bar_exp [0:7];

  initial begin
    bar_exp[0] = 7'b1111111; bar_exp[1] = 7'b0111111; bar_exp[2] = 7'b0011111;
    bar_exp[3] = 7'b0001111; bar_exp[4] = 7'b0000111; bar_exp[5] = 7'b0000011;
    bar_exp[6] = 7'b0000001; bar_exp[7] = 7'b0000000;

    // reset state
    step(); step();
    outs("reset", 7'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    outs("idle", 7'h00, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-COUNT
    do_start();
    outs("start", 7'b1111111, 1'b0, 1'b1, 1'b0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    chk("pre_rst_led", 32'(led), 32'(7'b0011111));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b1;
    step(); step();
    outs("post_rst", 7'h00, 1'b0, 1'b0, 1'b0);

    // full countdown; step 5 has all ticks together with step_cnt=3
    do_start();
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) pulse(1, 1, 1);
      else pulse(1, 0, 0);
      chk($sformatf("bar%0d_led", k), 32'(led), 32'(bar_exp[k]));
      chk($sformatf("bar%0d_win", k), 32'(win_pulse), (k == 7) ? 32'h1 : 32'h0);
    end
    step();
    outs("settle2", 7'h00, 1'b0, 1'b1, 1'b0);
    pulse(0, 1, 0);
    outs("settle_ign_flash", 7'h00, 1'b0, 1'b1, 1'b0);

    // right wins, two flashes, start ignored during SHOW
    result = 2'b10;
    pulse(0, 0, 1);
    outs("show_r1", 7'b0000111, 1'b0, 1'b1, 1'b0);
    do_start();
    outs("show_r1_start", 7'b0000111, 1'b0, 1'b1, 1'b0);
    pulse(0, 1, 0);
    outs("dark_r1", 7'h00, 1'b0, 1'b1, 1'b0);
    pulse(0, 1, 0);
    outs("show_r2", 7'b0000111, 1'b0, 1'b1, 1'b0);
    pulse(0, 1, 0);
    outs("dark_r2", 7'h00, 1'b0, 1'b1, 1'b0);
    pulse(0, 1, 0);
    outs("finish", 7'h00, 1'b0, 1'b1, 1'b1);
    pulse(0, 1, 1);
    outs("finish_ign", 7'h00, 1'b0, 1'b1, 1'b1);
    pulse(1, 0, 0);
    outs("back_idle", 7'h00, 1'b0, 1'b0, 1'b0);

    // tie latched; later change of result must not alter the display
    do_start();
    for (int k = 0; k < 7; k++) pulse(1, 0, 0);
    result = 2'b11;
    pulse(0, 0, 1);
    outs("show_t1", 7'b1110111, 1'b0, 1'b1, 1'b0);
    result = 2'b01;
    step();
    chk("show_t1_hold", 32'(led), 32'(7'b1110111));
    pulse(0, 1, 0);
    chk("dark_t1", 32'(led), 32'h0);
    pulse(0, 1, 0);
    chk("show_t2", 32'(led), 32'(7'b1110111));
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    chk("finish_t", 32'(done), 32'h1);
    pulse(1, 0, 0);

    // left pattern, then abort during SHOW
    do_start();
    for (int k = 0; k < 7; k++) pulse(1, 0, 0);
    result = 2'b01;
    pulse(0, 0, 1);
    chk("show_left", 32'(led), 32'(7'b1110000));
    abort = 1'b1;
    step();
    abort = 1'b0;
    outs("abort_show", 7'h00, 1'b0, 1'b0, 1'b0);

    // abort during SETTLE before tick_settle
    do_start();
    for (int k = 0; k < 7; k++) pulse(1, 0, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    outs("abort_settle", 7'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      pulse(1, 1, 1);
      chk($sformatf("post_abort%0d_win", k), 32'(win_pulse), 32'h0);
      chk($sformatf("post_abort%0d_done", k), 32'(done), 32'h0);
    end

    // start with abort in IDLE stays IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    outs("start_abort", 7'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
